// File: rtl/genx_qspi_pkg.sv
// Shared opcodes, FSM encoding and word-slice helpers for the QSPI handler.
package genx_qspi_pkg;

  localparam logic [7:0] OP_REG_WR  = 8'h02;
  localparam logic [7:0] OP_REG_RD  = 8'h03;
  localparam logic [7:0] OP_SMEM_WR = 8'h12;
  localparam logic [7:0] OP_SMEM_RD = 8'h13;

  localparam int WDATA_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_REQ    = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // LSB of word idx inside {x_h, x_l}: word 0 sits at the top of _h.
  function automatic logic [8:0] word_lsb(input logic [3:0] idx);
    return {~idx, 5'b0_0000};
  endfunction

endpackage

// File: rtl/genx_qspi_handler_if.sv
// Register/SMEM request-acknowledge bus driven by the QSPI handler.
interface genx_qspi_handler_if;
  logic        bus_req;
  logic        bus_write;
  logic [1:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_write, bus_sel, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_write, bus_sel, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/genx_pulse_sync.sv
// Multi-flop synchroniser for an SCK-domain level, followed by a rising-edge detector.
module genx_pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], level};
      prev <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/genx_qspi_handler.sv
// QSPI transaction handler: notify edge detect, decode, 1..16 word bus sequencing.
// Optional QSPI_STATS_EN adds saturating read/write/err counters.
//   state  | meaning
//   IDLE   | waiting for a notify edge
//   DECODE | check select legality for the captured transfer
//   REQ    | drive address/data for the current word, raise bus_req
//   WAIT   | hold bus_req until bus_ack or timeout
module genx_qspi_handler
  import genx_qspi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          ACK_TIMEOUT = 64,
  parameter logic [31:0] RD_FILL     = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         notify_read,
  input  logic         notify_write,
  input  logic [7:0]   opcode,
  input  logic [31:0]  address,
  input  logic [1:0]   chip_select,
  input  logic [255:0] wdata_h,
  input  logic [255:0] wdata_l,
  output logic [255:0] rdata_h,
  output logic [255:0] rdata_l,
  genx_qspi_handler_if.master bus,
  output logic         busy,
  output logic         err
`ifdef QSPI_STATS_EN
  ,
  output logic [31:0]  stat_rd,
  output logic [31:0]  stat_wr,
  output logic [31:0]  stat_err
`endif
);

  localparam int            TW     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(ACK_TIMEOUT - 1);

  logic          rd_edge, wr_edge;
  state_t        state;
  logic          is_wr, to_seen;
  logic [1:0]    sel_q;
  logic [31:0]   addr_q;
  logic [511:0]  wd_q, rd_q;
  logic [3:0]    idx, last_idx;
  logic [TW-1:0] timer;
  logic          rd_op, wr_op, multi_op;

  genx_pulse_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .resetn(resetn), .level(notify_read), .rise(rd_edge)
  );
  genx_pulse_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .resetn(resetn), .level(notify_write), .rise(wr_edge)
  );

  assign rd_op    = (opcode == OP_REG_RD) || (opcode == OP_SMEM_RD);
  assign wr_op    = (opcode == OP_REG_WR) || (opcode == OP_SMEM_WR);
  assign multi_op = (opcode == OP_SMEM_RD) || (opcode == OP_SMEM_WR);
  assign rdata_h  = rd_q[511:256];
  assign rdata_l  = rd_q[255:0];
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      is_wr         <= 1'b0;
      to_seen       <= 1'b0;
      sel_q         <= '0;
      addr_q        <= '0;
      wd_q          <= '0;
      rd_q          <= '0;
      idx           <= '0;
      last_idx      <= '0;
      timer         <= '0;
      err           <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_write <= 1'b0;
      bus.bus_sel   <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_edge && rd_edge) err <= 1'b1;
          // A write edge wins; a read edge only starts a read-kind opcode.
          if ((wr_edge && wr_op) || (rd_edge && !wr_edge && rd_op)) begin
            is_wr    <= wr_edge;
            sel_q    <= ~chip_select;
            addr_q   <= address;
            wd_q     <= {wdata_h, wdata_l};
            last_idx <= multi_op ? 4'(WDATA_WORDS - 1) : 4'd0;
            idx      <= '0;
            to_seen  <= 1'b0;
            state    <= ST_DECODE;
            if (!wr_edge) rd_q <= '0;
          end
        end
        ST_DECODE: begin
          if (sel_q == 2'b00) begin
            state <= ST_IDLE;
          end else if (!is_wr && sel_q == 2'b11) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          bus.bus_req   <= 1'b1;
          bus.bus_write <= is_wr;
          bus.bus_sel   <= sel_q;
          bus.bus_addr  <= addr_q + {26'b0, idx, 2'b00};
          bus.bus_wdata <= is_wr ? wd_q[word_lsb(idx) +: 32] : 32'h0;
          timer         <= T_LOAD;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.bus_ack || timer == '0) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_ack && !to_seen) begin
              err     <= 1'b1;
              to_seen <= 1'b1;
            end
            if (!is_wr) rd_q[word_lsb(idx) +: 32] <= bus.bus_ack ? bus.bus_rdata : RD_FILL;
            if (idx == last_idx) begin
              state         <= ST_IDLE;
              bus.bus_write <= 1'b0;
              bus.bus_sel   <= '0;
              bus.bus_addr  <= '0;
              bus.bus_wdata <= '0;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_REQ;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (state != ST_IDLE && (rd_edge || wr_edge)) err <= 1'b1;
    end
  end

`ifdef QSPI_STATS_EN
  logic txn_end;
  assign txn_end = (state == ST_WAIT) && (bus.bus_ack || timer == '0) && (idx == last_idx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else begin
      if (txn_end && !is_wr && stat_rd != '1) stat_rd <= stat_rd + 32'd1;
      if (txn_end && is_wr && stat_wr != '1)  stat_wr <= stat_wr + 32'd1;
      if (err && stat_err != '1)              stat_err <= stat_err + 32'd1;
    end
  end
`endif

endmodule
